instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage feeding the IF/ID pipeline register. Owns the fetch PC, issues word reads to the
//  synchronous program ROM and buffers returned words in a small queue. Presents {pc+4, instr}
//  with a valid flag, holds it under hazard stall and flushes on branch/jump/jr redirect from MEM.
// PARAMETERS
//  RESET_PC  32'h0040_0000  fetch PC loaded on reset
//  DEPTH     2              instruction queue entries; power of two, >= 2
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high; clears all state
//  stall_i          in   1   hazard stall; IF/ID does not accept while high
//  redirect_i       in   1   taken branch/jump/jr resolved in MEM
//  redirect_pc_i    in   32  redirect target
//  imem_req_o       out  1   ROM read request this cycle
//  imem_addr_o      out  32  ROM word address (bits [1:0] always 00)
//  imem_rdata_i     in   32  ROM data, valid the cycle after imem_req_o
//  if_valid_o       out  1   if_instr_o / if_pc_plus_4_o hold a real instruction
//  if_instr_o       out  32  instruction to IF/ID
//  if_pc_plus_4_o   out  32  address of that instruction + 4
//  align_err_o      out  1   one-cycle pulse: redirect_pc_i[1:0] != 00
// BEHAVIOUR
//  - Reset values: fetch_pc=RESET_PC, queue empty, no fetch in flight, imem_req_o=0,
//    if_valid_o=0, if_instr_o=0, if_pc_plus_4_o=0, align_err_o=0.
//  - Handshake: pop = if_valid_o & ~stall_i. Outputs show the queue head; they hold while stalled.
//  - Issue: imem_req_o = ~redirect_i & (count + inflight - pop < DEPTH). On issue imem_addr_o =
//    fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); inflight <= 1 and
//    the issued pc+4 is recorded as the entry tag.
//  - Return: the cycle after an issue, {tag, imem_rdata_i} is pushed unless killed. Push and pop
//    in the same cycle are legal at any occupancy; the credit rule makes overflow impossible.
//  - Throughput: DEPTH=2, stall_i=0 -> one instruction per cycle sustained.
//  - Latency: reset release at edge 0 -> req at cycle 0, if_valid_o=1 from cycle 2.
//  - Redirect in cycle R (priority over stall_i and any pending push):
//    queue cleared, in-flight return killed, fetch_pc <= {redirect_pc_i[31:2],2'b00};
//    no req in R; if_valid_o=0 in R+1 and R+2; req for target in R+1; target valid in R+3.
//    redirect_pc_i[1:0] != 00 -> align_err_o=1 in R+1, target still aligned down.
//  - Redirect while stalled: same flush; stall_i only gates popping, never issue after flush.
//  - Back-to-back redirects: the later one wins; the earlier target is never presented.
//  - Reset asserted mid-operation: all state cleared immediately (async); a ROM word returning
//    after reset release from a pre-reset request is discarded.
//  - if_valid_o=0 means bubble: IF/ID captures it and the control unit decodes it as a NOP.
// STRUCTURE
//  - Shared include mips_defs.vh: RESET_PC default, NOP encoding 32'h0000_0000, PC_INCR = 4.
//  - Sub-module fetch_queue: DEPTH-entry, 64-bit synchronous FIFO (push, pop, flush, count,
//    head data), async active-high reset. Fetch PC, credit counter, kill flag and align_err
//    live in instruction_fetch_unit.
// TESTING
//  1 Reset release, ROM[0x400000]=0x20080005, [..04]=0x20090003, stall_i=0 -> cycle 2:
//    valid, instr 0x20080005, pc+4 0x00400004; cycle 3: 0x20090003, pc+4 0x00400008.
//  2 stall_i high cycles 3-6 -> outputs frozen at pc+4 0x00400008, imem_req_o=0 once
//    count+inflight=2; release -> 0x0040000C next cycle, no skip, no duplicate.
//  3 redirect_i in cycle 5, redirect_pc_i=0x00400040 -> if_valid_o=0 cycles 6-7,
//    cycle 8 pc+4 0x00400044; no word from 0x00400010.. ever presented.
//  4 redirect_i with stall_i=1 and queue full, target 0x00400080 -> queue flushed,
//    target presented 3 cycles later once stall_i drops.
//  5 redirect_pc_i=0x00400022 -> align_err_o pulses once, fetch at 0x00400020.
//  6 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000;
//    pc+4 outputs FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared constants and types for the fetch stage.
//   - RESET_PC_DEFAULT : fetch PC loaded on reset when not overridden
//   - NOP_INSTR        : encoding presented while no instruction is valid
//   - PC_INCR          : byte distance between consecutive instruction words
//   - fetch_entry_t    : one queue entry, {pc + 4, instruction word}
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bundles the fetch stage's ROM bus, IF/ID outputs and pipeline controls.
//   master : the fetch unit (drives ROM request and IF/ID outputs)
//   slave  : the surroundings (ROM data, hazard stall, MEM redirect)
//   Signals:
//     stall_i, redirect_i, redirect_pc_i  pipeline control into the fetch unit
//     imem_req_o, imem_addr_o             ROM read request / word address
//     imem_rdata_i                        ROM data, one cycle after the request
//     if_valid_o, if_instr_o,
//     if_pc_plus_4_o                      instruction presented to IF/ID
//     align_err_o                         misaligned redirect target pulse
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if;

    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_plus_4_o;
    logic        align_err_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, if_valid_o, if_instr_o,
               if_pc_plus_4_o, align_err_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o,
               if_pc_plus_4_o, align_err_o
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   DEPTH-entry synchronous FIFO of fetch_entry_t (64 bits).
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     push         write push_data at the tail
//     pop          drop the head entry
//     flush        empty the queue; overrides push and pop
//     push_data    entry to write
//     head_data    current head entry (meaningless while count == 0)
//     count        number of valid entries, 0..DEPTH
//   The caller guarantees no push when full without a same-cycle pop and no
//   pop when empty. DEPTH must be a power of two so the pointers wrap freely.
// ----------------------------------------------------------------------------
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               push_data,
    output fetch_entry_t               head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is tracked
    // by count alone, which keeps the array a plain RAM without reset muxes.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage feeding IF/ID. Owns the fetch PC, issues word reads to a
//   synchronous ROM and buffers returned words in fetch_queue.
//   Ports:
//     clk     rising-edge clock
//     reset   asynchronous active-high reset, clears all state
//     bus     instruction_fetch_unit_if.master (ROM bus, IF/ID outputs,
//             stall / redirect controls, align_err_o)
//   Issue uses a credit rule: a request goes out only if the queue can hold
//   every word already buffered or in flight after this cycle's pop, so the
//   queue never overflows and DEPTH=2 sustains one instruction per cycle.
// ----------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_tag;
    logic          align_err_q;

    logic          kill;
    logic          issue;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW:0]   occupancy;
    logic [CW-1:0] count;
    logic [31:0]   next_pc;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    // A redirect flushes the queue and discards the word returning this cycle.
    assign kill       = bus.redirect_i;
    assign head_valid = (count != '0);
    assign pop        = head_valid & ~bus.stall_i;
    assign push       = inflight & ~kill;
    assign next_pc    = fetch_pc + PC_INCR;

    // Entries held after this cycle's pop plus the one possibly returning.
    assign occupancy  = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    // Gated by reset so no request is seen while reset is held.
    assign issue      = ~reset & ~kill & (occupancy < DEPTH_W);

    assign push_entry = '{pc_plus_4: inflight_tag, instr: bus.imem_rdata_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            align_err_q  <= 1'b0;
        end else begin
            align_err_q <= kill & (bus.redirect_pc_i[1:0] != 2'b00);
            if (kill) begin
                fetch_pc <= {bus.redirect_pc_i[31:2], 2'b00};
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    fetch_pc     <= next_pc;
                    inflight_tag <= next_pc;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (kill),
        .push_data (push_entry),
        .head_data (head),
        .count     (count)
    );

    // Bubbles are presented as NOP with a zero pc+4.
    // NOTE: every output is given a default before any condition so the
    // block stays purely combinational and cannot infer a latch.
    always_comb begin
        bus.if_valid_o     = 1'b0;
        bus.if_instr_o     = NOP_INSTR;
        bus.if_pc_plus_4_o = '0;
        if (head_valid) begin
            bus.if_valid_o     = 1'b1;
            bus.if_instr_o     = head.instr;
            bus.if_pc_plus_4_o = head.pc_plus_4;
        end
    end

    assign bus.imem_req_o  = issue;
    assign bus.imem_addr_o = {fetch_pc[31:2], 2'b00};
    assign bus.align_err_o = align_err_q;

endmodule
